agc_uplink_tx: RTL and testbench

- Bench/peripheral transmitter that drives the AGC uplink pulse lines UPL0/UPL1 into the gate-level uplink receiver.
- Takes a 5-bit keycode or a raw 15-bit word and emits it MSB first, one bit per fixed bit period.
- Each bit is a single pulse on upl1 for a 1 or on upl0 for a 0.
- Outputs are registered on SIM_CLK so they feed nor_* gate inputs glitch-free, the same way gate outputs change.

---
 rtl/agc_uplink_tx.sv | 116 +++++++++++
 tb/tb_agc_uplink_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_uplink_tx.sv
// AGC uplink pulse transmitter: serialises a keycode or raw 15-bit word MSB first
// as single pulses on upl1 (one) or upl0 (zero), with all outputs registered.
module agc_uplink_tx #(
   parameter int PULSE_W    = 8,
   parameter int BIT_PERIOD = 32,
   parameter int WORD_GAP   = 64
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST,
   input  logic        fmt,
   input  logic [4:0]  key,
   input  logic [14:0] word_in,
   input  logic        key_valid,
   output logic        key_ready,
   output logic        upl0,
   output logic        upl1,
   output logic        busy,
   output logic        word_done
);

   localparam int SPACE_W = BIT_PERIOD - PULSE_W;
   localparam int CNT_MAX = (BIT_PERIOD > WORD_GAP) ? BIT_PERIOD : WORD_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] SPACE_LAST = CW'(SPACE_W - 1);
   localparam logic [CW-1:0] GAP_LAST   = (WORD_GAP > 0) ? CW'(WORD_GAP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_SPACE,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [14:0]   shreg_q, shreg_d;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (key_ready && key_valid) begin
               shreg_d = fmt ? {key, ~key, key} : word_in;
               idx_d   = 4'd14;
               state_d = S_PULSE;
            end
         end
         S_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = S_SPACE;
            end
         end
         S_SPACE: begin
            if (cnt_q == SPACE_LAST) begin
               cnt_d = '0;
               if (idx_q != 4'd0) begin
                  shreg_d = {shreg_q[13:0], 1'b0};
                  idx_d   = idx_q - 4'd1;
                  state_d = S_PULSE;
               end else if (WORD_GAP == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are computed from next-state so they change on the same edge as the
   // state register; key_ready is held low until the first edge after reset.
   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         key_ready <= 1'b0;
         busy      <= 1'b0;
         word_done <= 1'b0;
         upl0      <= 1'b0;
         upl1      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         key_ready <= (state_d == S_IDLE);
         busy      <= (state_d != S_IDLE);
         word_done <= (state_d == S_IDLE) && (state_q != S_IDLE);
         upl1      <= (state_d == S_PULSE) &&  shreg_d[14];
         upl0      <= (state_d == S_PULSE) && !shreg_d[14];
      end
   end

endmodule

// File: tb/tb_agc_uplink_tx.sv
// Scoreboard bench for agc_uplink_tx: channel 0 uses default timing, channel 1
// uses PULSE_W=1, BIT_PERIOD=2, WORD_GAP=0.
`timescale 1ns/1ps
module tb_agc_uplink_tx;

   typedef struct packed {
      logic        bitv;
      logic [31:0] cyc;
   } pexp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        fmt_r   [2];
   logic [4:0]  key_r   [2];
   logic [14:0] word_r  [2];
   logic        valid_r [2];
   logic        rdy_w   [2];
   logic        upl0_w  [2];
   logic        upl1_w  [2];
   logic        busy_w  [2];
   logic        done_w  [2];

   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pexp_t       pq0[$], pq1[$];
   int unsigned dq0[$], dq1[$];

   agc_uplink_tx dut (
      .SIM_CLK(clk), .SIM_RST(rst_n), .fmt(fmt_r[0]), .key(key_r[0]),
      .word_in(word_r[0]), .key_valid(valid_r[0]), .key_ready(rdy_w[0]),
      .upl0(upl0_w[0]), .upl1(upl1_w[0]), .busy(busy_w[0]), .word_done(done_w[0])
   );

   agc_uplink_tx #(.PULSE_W(1), .BIT_PERIOD(2), .WORD_GAP(0)) dut_fast (
      .SIM_CLK(clk), .SIM_RST(rst_n), .fmt(fmt_r[1]), .key(key_r[1]),
      .word_in(word_r[1]), .key_valid(valid_r[1]), .key_ready(rdy_w[1]),
      .upl0(upl0_w[1]), .upl1(upl1_w[1]), .busy(busy_w[1]), .word_done(done_w[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pw(input int ch); return (ch == 0) ? 8  : 1; endfunction
   function automatic int bp(input int ch); return (ch == 0) ? 32 : 2; endfunction
   function automatic int wg(input int ch); return (ch == 0) ? 64 : 0; endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pq_size(input int ch); return (ch == 0) ? pq0.size() : pq1.size(); endfunction
   function automatic int dq_size(input int ch); return (ch == 0) ? dq0.size() : dq1.size(); endfunction

   function automatic pexp_t pq_pop(input int ch);
      if (ch == 0) return pq0.pop_front();
      return pq1.pop_front();
   endfunction

   function automatic int unsigned dq_pop(input int ch);
      if (ch == 0) return dq0.pop_front();
      return dq1.pop_front();
   endfunction

   // Monitor: pops an expected bit at every pulse start and an expected cycle at every word_done.
   logic p0 [2];
   logic p1 [2];
   int   wid[2];

   initial begin
      for (int ch = 0; ch < 2; ch++) begin p0[ch] = 1'b0; p1[ch] = 1'b0; wid[ch] = 0; end
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            if (!rst_n) begin
               p0[ch] = 1'b0; p1[ch] = 1'b0; wid[ch] = 0;
            end else begin
               check($sformatf("ch%0d_excl", ch), 32'(upl0_w[ch] & upl1_w[ch]), 32'd0);
               if ((upl0_w[ch] && !p0[ch]) || (upl1_w[ch] && !p1[ch])) begin
                  if (pq_size(ch) == 0) begin
                     check($sformatf("ch%0d_extra_pulse", ch), 32'({upl1_w[ch], upl0_w[ch]}), 32'd0);
                  end else begin
                     pexp_t e;
                     e = pq_pop(ch);
                     check($sformatf("ch%0d_bit", ch), 32'(upl1_w[ch]), 32'(e.bitv));
                     check($sformatf("ch%0d_pulse_start", ch), cyc, e.cyc);
                  end
                  wid[ch] = 0;
               end
               if (upl0_w[ch] || upl1_w[ch]) wid[ch]++;
               else if (p0[ch] || p1[ch]) check($sformatf("ch%0d_width", ch), 32'(wid[ch]), 32'(pw(ch)));
               if (done_w[ch]) begin
                  if (dq_size(ch) == 0) begin
                     check($sformatf("ch%0d_extra_done", ch), 32'(done_w[ch]), 32'd0);
                  end else begin
                     check($sformatf("ch%0d_done_cycle", ch), cyc, dq_pop(ch));
                     check($sformatf("ch%0d_done_busy", ch), 32'(busy_w[ch]), 32'd0);
                     check($sformatf("ch%0d_done_ready", ch), 32'(rdy_w[ch]), 32'd1);
                  end
               end
               p0[ch] = upl0_w[ch];
               p1[ch] = upl1_w[ch];
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge with key_valid still high.
   task automatic issue(input int ch, input logic f, input logic [4:0] k, input logic [14:0] w,
                        input logic [14:0] exp_word, output int unsigned acc);
      int    n;
      pexp_t e;
      n = 0;
      fmt_r[ch] = f; key_r[ch] = k; word_r[ch] = w; valid_r[ch] = 1'b1;
      while (rdy_w[ch] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      check($sformatf("ch%0d_accept_wait", ch), 32'(rdy_w[ch]), 32'd1);
      acc = cyc + 1;
      for (int i = 0; i < 15; i++) begin
         e.bitv = exp_word[14-i];
         e.cyc  = acc + 32'(i * bp(ch));
         if (ch == 0) pq0.push_back(e); else pq1.push_back(e);
      end
      if (ch == 0) dq0.push_back(acc + 32'(15 * bp(ch) + wg(ch)));
      else         dq1.push_back(acc + 32'(15 * bp(ch) + wg(ch)));
      @(negedge clk);
      check($sformatf("ch%0d_busy_after_accept", ch), 32'(busy_w[ch]), 32'd1);
   endtask

   task automatic wait_done(input int ch);
      int n;
      n = 0;
      while ((pq_size(ch) != 0 || dq_size(ch) != 0) && n < 5000) begin @(negedge clk); n++; end
      check($sformatf("ch%0d_drain", ch), 32'(pq_size(ch) + dq_size(ch)), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc, acc2;
      int          act, n;
      for (int ch = 0; ch < 2; ch++) begin
         fmt_r[ch] = 1'b0; key_r[ch] = '0; word_r[ch] = '0; valid_r[ch] = 1'b0;
      end

      // Reset release and idle behaviour.
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(rdy_w[0]), 32'd0);
      check("rst_lines", 32'({upl1_w[0], upl0_w[0], busy_w[0], done_w[0]}), 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(rdy_w[0]), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(rdy_w[0]), 32'd1);
      check("ready_after_edge_fast", 32'(rdy_w[1]), 32'd1);
      act = 0;
      repeat (100) begin
         @(negedge clk);
         if (upl0_w[0] || upl1_w[0] || busy_w[0] || done_w[0]) act++;
      end
      check("idle_activity", 32'(act), 32'd0);

      // Keycode 10011 with stray requests during SPACE and GAP.
      issue(0, 1'b1, 5'b10011, 15'h0000, 15'h4D93, acc);
      valid_r[0] = 1'b0;
      repeat (40) @(negedge clk);
      key_r[0] = 5'h00; valid_r[0] = 1'b1;
      @(negedge clk);
      valid_r[0] = 1'b0;
      n = 0;
      while (cyc < acc + 500 && n < 1000) begin @(negedge clk); n++; end
      fmt_r[0] = 1'b0; word_r[0] = 15'h7FFF; valid_r[0] = 1'b1;
      @(negedge clk);
      valid_r[0] = 1'b0;
      wait_done(0);

      // Raw words: all zeros then all ones.
      issue(0, 1'b0, 5'h00, 15'h0000, 15'h0000, acc);
      valid_r[0] = 1'b0;
      wait_done(0);
      issue(0, 1'b0, 5'h00, 15'h7FFF, 15'h7FFF, acc);
      valid_r[0] = 1'b0;
      wait_done(0);

      // Back-to-back with key_valid held and key changed mid-word.
      issue(0, 1'b1, 5'h1F, 15'h0000, 15'h7C1F, acc);
      issue(0, 1'b1, 5'h00, 15'h0000, 15'h03E0, acc2);
      valid_r[0] = 1'b0;
      check("b2b_accept", acc2, acc + 32'd545);
      wait_done(0);

      // Reset in the middle of the eighth pulse.
      issue(0, 1'b1, 5'b10011, 15'h0000, 15'h4D93, acc);
      valid_r[0] = 1'b0;
      n = 0;
      while (cyc < acc + 7 * 32 + 3 && n < 1000) begin @(negedge clk); n++; end
      check("pre_reset_pulse", 32'(upl1_w[0]), 32'd1);
      pq0.delete();
      dq0.delete();
      #2 rst_n = 1'b0;
      #1;
      check("reset_lines", 32'({upl1_w[0], upl0_w[0]}), 32'd0);
      check("reset_busy", 32'(busy_w[0]), 32'd0);
      check("reset_ready", 32'(rdy_w[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rerelease_ready_before_edge", 32'(rdy_w[0]), 32'd0);
      @(negedge clk);
      check("rerelease_ready_after_edge", 32'(rdy_w[0]), 32'd1);
      issue(0, 1'b1, 5'b01101, 15'h0000, 15'h364D, acc);
      valid_r[0] = 1'b0;
      wait_done(0);

      // Fast timing: 1-cycle pulses, 2-cycle pitch, no gap.
      issue(1, 1'b1, 5'b10011, 15'h0000, 15'h4D93, acc);
      valid_r[1] = 1'b0;
      wait_done(1);
      issue(1, 1'b0, 5'h00, 15'h2AAA, 15'h2AAA, acc);
      valid_r[1] = 1'b0;
      wait_done(1);
      issue(1, 1'b1, 5'h1F, 15'h0000, 15'h7C1F, acc);
      issue(1, 1'b1, 5'h00, 15'h0000, 15'h03E0, acc2);
      valid_r[1] = 1'b0;
      check("fast_b2b_accept", acc2, acc + 32'd31);
      wait_done(1);

      repeat (5) @(negedge clk);
      check("final_queues_ch0", 32'(pq0.size() + dq0.size()), 32'd0);
      check("final_queues_ch1", 32'(pq1.size() + dq1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
